// File: rtl/sram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sram_fifo_ctrl.
// The producer/consumer side uses the master modport, the FIFO uses slave.
interface sram_fifo_if #(
  parameter int DATA_WIDTH = 72
);
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [DATA_WIDTH-1:0] pop_data;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Ready/valid FIFO built around one 1W1R SRAM macro with registered inputs.
// Writes go straight to the macro; reads are launched ahead of demand and the
// one-cycle read latency is absorbed by a 2-entry output buffer so the stream
// runs at one word per cycle without bubbles.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  sram_fifo_if.slave            bus,
  output logic [5:0]            count,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int                    CNT_W     = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);

  // Pointers wrap at DEPTH-1, not at the power-of-two address range.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [CNT_W-1:0]      sram_cnt_reg;   // written, not yet read-launched
  logic                  rd_pend_reg;    // read launched last cycle
  logic [1:0]            obuf_cnt_reg;
  logic                  obuf_head_reg;

  logic                  push_ready;
  logic                  push_fire;
  logic                  pop_valid;
  logic                  pop_fire;
  logic                  rd_launch;
  logic [2:0]            obuf_after;     // obuf occupancy next cycle before new reads
  logic                  obuf_tail;
  logic [CNT_W-1:0]      sram_cnt_next;
  logic [DATA_WIDTH-1:0] obuf_data [2];

  assign push_ready = (sram_cnt_reg != FULL_CNT) && !flush;
  assign push_fire  = bus.push_valid && push_ready;
  assign pop_valid  = (obuf_cnt_reg != 2'd0);
  assign pop_fire   = pop_valid && bus.pop_ready;

  // Launch a read only if the word is guaranteed a slot in obuf when it lands.
  assign obuf_after = {1'b0, obuf_cnt_reg} + {2'b00, rd_pend_reg} - {2'b00, pop_fire};
  assign rd_launch  = !flush && (sram_cnt_reg != '0) && (obuf_after < 3'd2);

  assign sram_cnt_next = sram_cnt_reg + CNT_W'(push_fire) - CNT_W'(rd_launch);

  // A landing read can only meet obuf with at most one word in it, so the
  // tail is the head plus the low occupancy bit.
  assign obuf_tail = obuf_head_reg ^ obuf_cnt_reg[0];

  // Macro port drive; the write strobe is masked while reset is held so a
  // pending push_valid can never reach the array.
  assign sram_csb0  = !(push_fire && rst_n);
  assign sram_addr0 = wr_ptr_reg;
  assign sram_din0  = bus.push_data;
  assign sram_csb1  = !rd_launch;
  assign sram_addr1 = rd_ptr_reg;

  assign bus.push_ready = push_ready;
  assign bus.pop_valid  = pop_valid;
  assign bus.pop_data   = obuf_data[obuf_head_reg];

  assign count = 6'(sram_cnt_reg) + 6'(rd_pend_reg) + 6'(obuf_cnt_reg);

  // Pointer, occupancy and read-pipeline state; flush clears it all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      sram_cnt_reg  <= '0;
      rd_pend_reg   <= 1'b0;
      obuf_cnt_reg  <= 2'd0;
      obuf_head_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      sram_cnt_reg  <= '0;
      rd_pend_reg   <= 1'b0;
      obuf_cnt_reg  <= 2'd0;
      obuf_head_reg <= 1'b0;
    end else begin
      if (push_fire) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (rd_launch) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (pop_fire) begin
        obuf_head_reg <= ~obuf_head_reg;
      end
      sram_cnt_reg <= sram_cnt_next;
      rd_pend_reg  <= rd_launch;
      obuf_cnt_reg <= obuf_after[1:0];
    end
  end

  // Output buffer storage: each entry captures macro read data when it is the tail.
  for (genvar gi = 0; gi < 2; gi++) begin : g_obuf
    logic [DATA_WIDTH-1:0] data_reg;

    // Capture the landing read word; a flush drops it.
    always_ff @(posedge clk) begin
      if (rd_pend_reg && !flush && (obuf_tail == 1'(gi))) begin
        data_reg <= sram_dout1;
      end
    end

    assign obuf_data[gi] = data_reg;
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed + randomized bench for sram_fifo_ctrl with a behavioral macro model
// and a queue scoreboard of words accepted but not yet popped.
module tb_sram_fifo_ctrl;
  localparam int DW    = 72;
  localparam int AW    = 6;
  localparam int DEPTH = 40;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [5:0]    count;
  logic          sram_csb0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout1 = '0;

  sram_fifo_if #(.DATA_WIDTH(DW)) bus ();

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .count      (count),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  always #5 clk = ~clk;

  // Macro model: inputs registered at posedge, array access at the next negedge.
  logic [DW-1:0] mem [64];
  logic          csb0_q = 1'b1;
  logic          csb1_q = 1'b1;
  logic [AW-1:0] a0_q = '0, a1_q = '0;
  logic [DW-1:0] d0_q = '0;

  always @(posedge clk) begin
    csb0_q <= sram_csb0;
    a0_q   <= sram_addr0;
    d0_q   <= sram_din0;
    csb1_q <= sram_csb1;
    a1_q   <= sram_addr1;
  end

  always @(negedge clk) begin
    if (!csb0_q) mem[a0_q] <= d0_q;
    if (!csb1_q) sram_dout1 <= mem[a1_q];
  end

  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Port-usage checker: addresses in range, never same-address read+write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!sram_csb0) chk("wr_addr_range", 32'(sram_addr0 < AW'(DEPTH)), 32'd1);
      if (!sram_csb1) chk("rd_addr_range", 32'(sram_addr1 < AW'(DEPTH)), 32'd1);
      if (!sram_csb0 && !sram_csb1)
        chk("addr_collision", 32'(sram_addr0 != sram_addr1), 32'd1);
    end
  end

  // One clock cycle: drive inputs, check count against scoreboard depth,
  // score any pop, record any accepted push, advance to posedge+1.
  task automatic tick(input logic pv, input logic [DW-1:0] pd, input logic pr,
                      input logic fl, output logic pushed);
    logic [DW-1:0] exp;
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_ready  = pr;
    flush          = fl;
    #1;
    chk("count_vs_sb", 32'(count), 32'(sb.size()));
    pushed = pv && bus.push_ready;
    if (bus.pop_valid === 1'b1 && pr) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", 32'(bus.pop_valid), 32'd0);
      end else begin
        exp = sb.pop_front();
        chkd("pop_data", bus.pop_data, exp);
      end
    end
    if (pushed === 1'b1) sb.push_back(pd);
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    bus.push_valid = 1'b0;
    flush          = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          p;
    logic          on;
    int            acc;
    logic [DW-1:0] d;

    bus.push_valid = 1'b1;
    bus.push_data  = '0;
    bus.pop_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_csb0", 32'(sram_csb0), 32'd1);
    chk("rst_csb1", 32'(sram_csb1), 32'd1);
    chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
    bus.push_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted mid-stream with push_valid held high.
    for (int i = 0; i < 4; i++) tick(1'b1, DW'(i + 7), 1'b0, 1'b0, p);
    bus.push_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("amid_count", 32'(count), 32'd0);
    chk("amid_csb0", 32'(sram_csb0), 32'd1);
    chk("amid_csb1", 32'(sram_csb1), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("amid_hold_csb0", 32'(sram_csb0), 32'd1);
    chk("amid_hold_count", 32'(count), 32'd0);
    sb.delete();
    bus.push_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency after reset: push 0x5A, pop_valid in cycle 3.
    tick(1'b1, 72'h5A, 1'b1, 1'b0, p);
    chk("lat_push", 32'(p), 32'd1);
    chk("lat_c1_pv", 32'(bus.pop_valid), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("lat_c2_pv", 32'(bus.pop_valid), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("lat_c3_pv", 32'(bus.pop_valid), 32'd1);
    chkd("lat_c3_data", bus.pop_data, 72'h5A);
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("lat_c4_count", 32'(count), 32'd0);

    // Single word with count tracking.
    tick(1'b1, {9{8'hA5}}, 1'b1, 1'b0, p);
    chk("sw_c1_count", 32'(count), 32'd1);
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("sw_c2_count", 32'(count), 32'd1);
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("sw_c3_pv", 32'(bus.pop_valid), 32'd1);
    chkd("sw_c3_data", bus.pop_data, {9{8'hA5}});
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("sw_c4_count", 32'(count), 32'd0);
    chk("sw_c4_pv", 32'(bus.pop_valid), 32'd0);

    // Fill to capacity and drain, three times so pointers wrap.
    for (int rep = 0; rep < 3; rep++) begin
      acc = 0;
      for (int c = 0; c < 200 && acc < 42; c++) begin
        tick(1'b1, DW'(rep * 100 + acc), 1'b0, 1'b0, p);
        if (p === 1'b1) acc++;
      end
      chk("fill_accepted", 32'(acc), 32'd42);
      repeat (3) tick(1'b1, DW'(999), 1'b0, 1'b0, p);
      chk("fill_count", 32'(count), 32'd42);
      chk("fill_push_ready", 32'(bus.push_ready), 32'd0);
      for (int c = 0; c < 200 && sb.size() != 0; c++) tick(1'b0, '0, 1'b1, 1'b0, p);
      chk("drain_empty", 32'(sb.size()), 32'd0);
      tick(1'b0, '0, 1'b1, 1'b0, p);
    end

    // Streaming: 200 words, one pop per cycle from cycle 3 with no gaps.
    for (int i = 0; i < 203; i++) begin
      if (i >= 3) chk("stream_pop_valid", 32'(bus.pop_valid), 32'd1);
      d = {8'($urandom), $urandom, $urandom};
      tick(logic'(i < 200), d, 1'b1, 1'b0, p);
      if (i < 200) chk("stream_push", 32'(p), 32'd1);
    end
    chk("stream_empty", 32'(sb.size()), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0, p);

    // Back-pressure: bursty producer, consumer stalls ~30% of cycles.
    acc = 0;
    on  = 1'b1;
    d   = {8'($urandom), $urandom, $urandom};
    for (int c = 0; c < 5000 && (acc < 500 || sb.size() != 0); c++) begin
      if ($urandom_range(0, 9) == 0) on = ~on;
      tick(on && (acc < 500), d, logic'($urandom_range(0, 9) >= 3), 1'b0, p);
      if (p === 1'b1) begin
        acc++;
        d = {8'($urandom), $urandom, $urandom};
      end
    end
    chk("bp_pushed", 32'(acc), 32'd500);
    chk("bp_empty", 32'(sb.size()), 32'd0);
    tick(1'b0, '0, 1'b0, 1'b0, p);

    // Flush with a read in flight and ten words held.
    acc = 0;
    for (int c = 0; c < 50 && acc < 10; c++) begin
      tick(1'b1, DW'(500 + acc), 1'b0, 1'b0, p);
      if (p === 1'b1) acc++;
    end
    repeat (3) tick(1'b0, '0, 1'b0, 1'b0, p);
    tick(1'b1, DW'(600), 1'b1, 1'b0, p);
    chk("flush_pre_count", 32'(count), 32'd10);
    bus.push_valid = 1'b1;
    bus.push_data  = DW'(700);
    bus.pop_ready  = 1'b0;
    flush          = 1'b1;
    #1;
    chk("flush_push_ready", 32'(bus.push_ready), 32'd0);
    chk("flush_csb0", 32'(sram_csb0), 32'd1);
    chk("flush_csb1", 32'(sram_csb1), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.push_valid = 1'b0;
    sb.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_pv", 32'(bus.pop_valid), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("flush_stale_pv", 32'(bus.pop_valid), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("flush_stale_pv2", 32'(bus.pop_valid), 32'd0);

    tick(1'b1, 72'h1, 1'b1, 1'b0, p);
    chk("pf_c1_pv", 32'(bus.pop_valid), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("pf_c2_pv", 32'(bus.pop_valid), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("pf_c3_pv", 32'(bus.pop_valid), 32'd1);
    chkd("pf_c3_data", bus.pop_data, 72'h1);
    tick(1'b0, '0, 1'b1, 1'b0, p);
    chk("pf_end_count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Sequencing controller that turns one 1W1R SRAM macro (40 words x 72 bits, registered inputs, active-low chip selects) into a ready/valid FIFO. It owns the write and read pointers, launches one macro write and one macro read per cycle, and absorbs the macro's one-cycle read latency in a 2-entry output buffer. Result: a gap-free 1-word/cycle stream. It sits between a producer and consumer in the same clock domain and is the only driver of the macro's ports.

## Interface
- DATA_WIDTH, 72, word width; matches the macro.
- ADDR_WIDTH, 6, macro address width.
- DEPTH, 40, usable macro words. Pointers wrap at DEPTH-1 -> 0, not at 2^ADDR_WIDTH.
- clk  in  1  single clock for the controller and both macro ports (clk0 = clk1 = clk at the macro).
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all FIFO contents.
- push_valid / push_ready  in / out  1 / 1  producer handshake.
- push_data  in  DATA_WIDTH  write word.
- pop_valid / pop_ready  out / in  1 / 1  consumer handshake.
- pop_data  out  DATA_WIDTH  head word.
- count  out  6  words held: SRAM + in-flight read + output buffer, range 0..42.
- sram_csb0, sram_addr0, sram_din0  out  1 / ADDR_WIDTH / DATA_WIDTH  macro write port.
- sram_csb1, sram_addr1  out  1 / ADDR_WIDTH  macro read port.
- sram_dout1  in  DATA_WIDTH  macro read data.

## Operation
- State: wr_ptr and rd_ptr (0..DEPTH-1); sram_cnt (0..DEPTH, words written but not yet read-launched); rd_pend (read launched last cycle); obuf (2-entry register FIFO) with obuf_cnt (0..2).
- push_ready = (sram_cnt != DEPTH) && !flush.
- push_fire = push_valid && push_ready. It drives sram_csb0=0, sram_addr0=wr_ptr and sram_din0=push_data combinationally in the same cycle, then increments wr_ptr with wrap.
- pop_fire = pop_valid && pop_ready. pop_valid = (obuf_cnt != 0); pop_data = obuf head.
- rd_launch = !flush && sram_cnt != 0 && (obuf_cnt + rd_pend - pop_fire) < 2.
  - rd_launch drives sram_csb1=0 and sram_addr1=rd_ptr, then increments rd_ptr with wrap and sets rd_pend.
- When rd_pend=1, sram_dout1 is written into the obuf tail at the end of that cycle.
- sram_cnt next = sram_cnt + push_fire - rd_launch. obuf_cnt next = obuf_cnt + rd_pend - pop_fire.
- When idle, sram_csb0 and sram_csb1 are 1. Address and data lines are don't-care.
- Invariant: the controller never drives sram_csb0=0 and sram_csb1=0 with sram_addr0==sram_addr1 in the same cycle.
  - This holds because rd_ptr==wr_ptr only when the FIFO is empty (no read) or full (no write).
- flush=1: at the clock edge, pointers, sram_cnt, rd_pend and obuf_cnt are cleared, and in-flight read data is discarded. During the flush cycle no macro access is launched and push_ready=0.
- Flush and push in the same cycle: the push is not accepted.

## Timing
- Reset (rst_n low, asynchronous): all state is 0. Outputs while reset is held:
  - pop_valid=0, count=0.
  - sram_csb0=1 and sram_csb1=1, forced combinationally regardless of push_valid.
  - push_ready=1, but no push is accepted until rst_n is high.
- Write: push accepted in cycle N, the macro samples it at the end of N, and the array is updated at the following negedge.
- Read: launched in cycle N, sram_dout1 is valid before the end of cycle N+1, and captured into obuf at the end of N+1.
- Write-to-read: the earliest launch of a word pushed in cycle N is N+1. This is safe because the macro write completes before the read's sampling edge.
- Latency into an empty FIFO: push in cycle 0 gives pop_valid=1 in cycle 3.
- Throughput: sustained 1 push and 1 pop per cycle with no bubbles once obuf holds 1 word with 1 read pending.
- count updates one cycle after the causing handshake.
- Capacity: with pop_ready=0 the FIFO holds 42 words (40 in SRAM + 2 in obuf). push_ready falls in the cycle after the 40th word that stays resident in SRAM.

## Test plan
- Reset: assert rst_n low mid-stream with push_valid=1 -> asynchronously pop_valid=0, count=0, sram_csb0=sram_csb1=1. After release, push 0x5A -> pop_valid in cycle 3 with pop_data=0x5A.
- Single word: push 72'hA5A5...A5 at cycle 0 with pop_ready=1 -> count=1 from cycle 1, pop_valid and data at cycle 3, count=0 at cycle 4.
- Fill/wrap: push 0..41 with pop_ready=0 -> count=42, push_ready=0. Drain -> 0..41 in order. Repeat 3 times so pointers cross 39->0 -> order preserved.
- Streaming: push_valid=pop_ready=1 for 200 words -> from cycle 3, one pop per cycle with no gaps, in order. A checker confirms no same-address csb0/csb1 collision.
- Back-pressure: random pop_ready (about 30% low) and bursty push_valid for 500 words -> scoreboard shows no loss, duplication or reorder. count always equals the scoreboard depth.
- Flush: assert flush with rd_pend=1 and count=10 -> next cycle count=0, pop_valid=0, stale read data dropped. Then push 0x1 -> pops 0x1 three cycles later.
